// File: rtl/calc_sequencer.sv
// ============================================================================
// Module   : calc_sequencer (with adder_subtractor_nbit)
// Brief    : Add/sub/multiply/clear sequencer; shift-add multiply through one adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_subtractor_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow
);
  logic [n-1:0] w_y_eff;
  logic [n:0]   w_sum;

  // add_n=1 selects x - y as x + ~y + 1
  assign w_y_eff  = y ^ {n{add_n}};
  assign w_sum    = {1'b0, x} + {1'b0, w_y_eff} + {{n{1'b0}}, add_n};
  assign s        = w_sum[n-1:0];
  assign c_out    = w_sum[n];
  assign overflow = (x[n-1] == w_y_eff[n-1]) && (w_sum[n-1] != x[n-1]);
endmodule

module calc_sequencer #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] result,
  output logic           overflow,
  output logic           c_out
);
  localparam int CW = $clog2(n) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDSUB = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_MDONE  = 3'd3;
  localparam logic [2:0] S_CLR    = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [n-1:0]   a_q, a_d, b_q, b_d;
  logic           sub_q, sub_d;
  logic [n-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*n-1:0] result_q, result_d;
  logic           ovf_q, ovf_d, cout_q, cout_d, done_q, done_d;

  logic [n-1:0]   w_x, w_y, w_s;
  logic           w_add_n, w_cout, w_ovf;

  adder_subtractor_nbit #(.n(n)) u_addsub (
    .x        (w_x),
    .y        (w_y),
    .add_n    (w_add_n),
    .s        (w_s),
    .c_out    (w_cout),
    .overflow (w_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            2'b10:   state_d = S_MUL;
            2'b11:   state_d = S_CLR;
            default: state_d = S_ADDSUB;
          endcase
        end
      end
      S_MUL:   if (count_q == CW'(n - 1)) state_d = S_MDONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          sub_d    = op[0];
          acc_hi_d = '0;
          acc_lo_d = b;
          count_d  = '0;
        end
      end
      S_ADDSUB: begin
        result_d = {{n{w_s[n-1]}}, w_s};
        ovf_d    = w_ovf;
        cout_d   = w_cout;
        done_d   = 1'b1;
      end
      S_MUL: begin
        // Shift the partial sum right; its LSB becomes a product bit in acc_lo
        acc_hi_d = {w_cout, w_s[n-1:1]};
        acc_lo_d = {w_s[0], acc_lo_q[n-1:1]};
        count_d  = count_q + CW'(1);
      end
      S_MDONE: begin
        result_d = {acc_hi_q, acc_lo_q};
        ovf_d    = 1'b0;
        cout_d   = 1'b0;
        done_d   = 1'b1;
      end
      S_CLR: begin
        result_d = '0;
        ovf_d    = 1'b0;
        cout_d   = 1'b0;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_x     = '0;
    w_y     = '0;
    w_add_n = 1'b0;
    case (state_q)
      S_ADDSUB: begin
        w_x     = a_q;
        w_y     = b_q;
        w_add_n = sub_q;
      end
      S_MUL: begin
        w_x = acc_hi_q;
        w_y = acc_lo_q[0] ? a_q : '0;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign c_out    = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// Module   : tb_calc_sequencer
// Brief    : Randomized and directed checks of calc_sequencer against a latency/arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_sequencer;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           busy, done, overflow, c_out;
  logic [2*N-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  calc_sequencer #(.n(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .c_out    (c_out)
  );

  always #5 clk = ~clk;

  // Model: remaining cycles until completion plus the result computed arithmetically at acceptance
  int             rem = 0;
  logic [2*N-1:0] p_res, exp_res = '0;
  logic           p_ovf, p_cout, exp_ovf = 0, exp_cout = 0, exp_done = 0, exp_busy = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem = 0; exp_res = '0; exp_ovf = 0; exp_cout = 0; exp_done = 0; exp_busy = 0;
    end else begin
      exp_done = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          exp_res = p_res; exp_ovf = p_ovf; exp_cout = p_cout; exp_done = 1;
        end
      end else if (start) begin
        int sa, sb, ss, us;
        sa = $signed(a); sb = $signed(b);
        p_ovf = 0; p_cout = 0;
        case (op)
          2'b00: begin
            ss = sa + sb; us = int'(a) + int'(b);
            p_res = 8'($signed(4'(us)));
            p_cout = (us >= 16); p_ovf = (ss > 7) || (ss < -8);
          end
          2'b01: begin
            ss = sa - sb; us = int'(a) - int'(b);
            p_res = 8'($signed(4'(us)));
            p_cout = (a >= b); p_ovf = (ss > 7) || (ss < -8);
          end
          2'b10: p_res = 8'(int'(a) * int'(b));
          default: p_res = '0;
        endcase
        rem = (op == 2'b10) ? N + 1 : 1;
      end
      exp_busy = (rem > 0);
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if ({busy, done, result, overflow, c_out} !== {exp_busy, exp_done, exp_res, exp_ovf, exp_cout}) begin
      n_bad++;
      $display("FAIL cycle @%0t: got busy=%b done=%b result=%h ovf=%b cout=%b, expected busy=%b done=%b result=%h ovf=%b cout=%b",
               $time, busy, done, result, overflow, c_out, exp_busy, exp_done, exp_res, exp_ovf, exp_cout);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits for done; returns number of negedges waited (0 means timeout, already reported)
  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (done) begin lat = k; break; end
    end
    if (lat == 0) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [N-1:0] xa, input logic [N-1:0] xb,
                        input logic [7:0] er, input logic eo, input logic ec, input int ebusy);
    int lat;
    @(posedge clk); #2;
    start = 1; op = o; a = xa; b = xb;
    @(posedge clk); #2;
    start = 0;
    wait_done(nm, lat);
    if (lat != 0) begin
      chk({nm, "_busy_cycles"}, lat - 1, ebusy);
      chk({nm, "_result"}, result, er);
      chk({nm, "_ovf"}, overflow, eo);
      chk({nm, "_cout"}, c_out, ec);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ndone;
    @(negedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    #2 reset_n = 1;

    run_op("add_5_2",  2'b00, 4'd5, 4'd2, 8'h07, 0, 0, 1);
    run_op("add_7_1",  2'b00, 4'd7, 4'd1, 8'hF8, 1, 0, 1);
    run_op("sub_3_5",  2'b01, 4'd3, 4'd5, 8'hFE, 0, 0, 1);
    run_op("sub_5_3",  2'b01, 4'd5, 4'd3, 8'h02, 0, 1, 1);
    run_op("mul_15_15", 2'b10, 4'd15, 4'd15, 8'hE1, 0, 0, 5);
    run_op("mul_6_0",  2'b10, 4'd6, 4'd0, 8'h00, 0, 0, 5);
    run_op("mul_0_9",  2'b10, 4'd0, 4'd9, 8'h00, 0, 0, 5);

    // start and operand changes during a multiply must be ignored
    @(posedge clk); #2;
    start = 1; op = 2'b10; a = 4'd3; b = 4'd4;
    @(posedge clk); #2;
    op = 2'b00; a = 4'd9; b = 4'd7;
    repeat (3) @(posedge clk);
    #2 start = 0;
    wait_done("mul_busy_start", lat);
    chk("mul_busy_start_result", result, 8'h0C);
    ndone = (lat != 0) ? 1 : 0;
    repeat (4) begin @(negedge clk); #1; if (done) ndone++; end
    chk("mul_busy_start_done_count", ndone, 1);

    // back-to-back: start held high across the done cycle with clear
    @(posedge clk); #2;
    start = 1; op = 2'b00; a = 4'd5; b = 4'd2;
    @(posedge clk); #2;
    op = 2'b11;
    wait_done("b2b_add", lat);
    chk("b2b_add_result", result, 8'h07);
    @(posedge clk); #2;
    start = 0;
    @(negedge clk); #1;
    chk("b2b_clr_busy", {busy, done}, 2'b10);
    @(negedge clk); #1;
    chk("b2b_clr_done", {busy, done}, 2'b01);
    chk("b2b_clr_result", result, 8'h00);

    // asynchronous reset mid-multiply
    run_op("mul_pre", 2'b10, 4'd5, 4'd3, 8'h0F, 0, 0, 5);
    @(posedge clk); #2;
    start = 1; op = 2'b10; a = 4'd7; b = 4'd6;
    @(posedge clk); #2;
    start = 0;
    repeat (2) @(posedge clk);
    #3 reset_n = 0;
    #1;
    chk("rst_async_state", {busy, done, result}, 10'h000);
    @(posedge clk); #3 reset_n = 1;
    ndone = 0;
    repeat (8) begin @(negedge clk); #1; if (done || busy) ndone++; end
    chk("rst_no_late_done", ndone, 0);
    run_op("add_1_1", 2'b00, 4'd1, 4'd1, 8'h02, 0, 0, 1);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 2) != 0);
      op = 2'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
    end
    @(posedge clk); #2 start = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
